// File: rtl/mu0_uart_pkg.sv
// Shared opcodes, frame lengths, FSM state and command record for the mu0 debug UART protocol.
// Pure declarations; no latency or flow control of its own.
package mu0_uart_pkg;

  localparam logic [7:0] UART_OP_WRITE = 8'h57;
  localparam logic [7:0] UART_OP_READ  = 8'h52;
  localparam logic [7:0] UART_ACK      = 8'h4B;

  localparam logic [2:0] WR_FRAME_LEN = 3'd5;
  localparam logic [2:0] RD_FRAME_LEN = 3'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  // Big-endian frame layout: opcode, address, then write data.
  function automatic logic [7:0] frame_byte(input cmd_t cmd, input logic [2:0] idx);
    case (idx)
      3'd0:    frame_byte = cmd.write ? UART_OP_WRITE : UART_OP_READ;
      3'd1:    frame_byte = cmd.addr[15:8];
      3'd2:    frame_byte = cmd.addr[7:0];
      3'd3:    frame_byte = cmd.wdata[15:8];
      default: frame_byte = cmd.wdata[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte serialiser/deserialiser; TX start bit one cycle after tx_start, tx_done marks last stop-bit cycle.
// tx_start is taken only when idle or on tx_done (back-to-back); RX runs freely, rx_valid is a one-cycle strobe.
module uart_byte_phy #(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int CW = (DELAY_FRAMES > 2) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;

  assign tx_done = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= '1;
      uart_tx  <= 1'b1;
    end else if (tx_start && (!tx_busy || tx_done)) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= {1'b1, tx_byte};
      uart_tx  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          uart_tx <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          uart_tx  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  logic          rx_meta, rx_s, rx_prev, rx_act, rx_sample;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;

  // Start bit is checked at half a bit; every later sample lands mid-bit.
  assign rx_sample    = rx_act && (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST));
  assign rx_valid     = rx_sample && (rx_bit == 4'd9);
  assign rx_byte      = rx_shift;
  assign rx_frame_err = ~rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_act   <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= 4'd0;
      rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (!rx_act) begin
        if (rx_prev && !rx_s) begin
          rx_act <= 1'b1;
          rx_cnt <= '0;
          rx_bit <= 4'd0;
        end
      end else if (rx_sample) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_act <= 1'b0;
          else      rx_bit <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
        end else begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// UART command initiator: frames start on uart_tx the cycle after acceptance; rsp_valid one cycle after the reply/error.
// One command in flight; cmd_ready low from acceptance until after rsp_valid. UART_CMD_TIMEOUT_EN adds the reply timeout.
module uart_cmd_master
  import mu0_uart_pkg::*;
#(
  parameter int DELAY_FRAMES   = 234,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy
);

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [2:0] idx;
  logic [7:0] rd_hi;
  cmd_t       cmd_in, cmd_q;
  logic       accept, tx_start, tx_done, rx_valid, rx_frame_err, tmo_hit;
  logic [7:0] tx_byte, rx_byte;
  logic [2:0] last_idx;

  assign cmd_in   = {cmd_write, cmd_addr, cmd_wdata};
  assign accept   = cmd_valid && cmd_ready;
  assign busy     = ~cmd_ready;
  assign last_idx = cmd_q.write ? (WR_FRAME_LEN - 3'd1) : (RD_FRAME_LEN - 3'd1);

  // The opcode is launched straight from the inputs so the start bit lands the cycle after acceptance.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = frame_byte(cmd_in, 3'd0);
    if (accept) begin
      tx_start = 1'b1;
    end else if (state == SEND && tx_done && idx != last_idx) begin
      tx_start = 1'b1;
      tx_byte  = frame_byte(cmd_q, idx + 3'd1);
    end
  end

  uart_byte_phy #(.DELAY_FRAMES(DELAY_FRAMES)) u_phy (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx_done      (tx_done),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err)
  );

`ifdef UART_CMD_TIMEOUT_EN
  logic [23:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)                           tmo_cnt <= '0;
    else if (state != WAIT_RSP || rx_valid) tmo_cnt <= '0;
    else                                  tmo_cnt <= tmo_cnt + 24'd1;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TMO_LAST;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cmd_q     <= '0;
      rd_hi     <= 8'd0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cmd_q     <= cmd_in;
          idx       <= 3'd0;
          cmd_ready <= 1'b0;
          state     <= SEND;
        end
        SEND: if (tx_done) begin
          if (idx == last_idx) begin
            idx   <= 3'd0;
            state <= WAIT_RSP;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        WAIT_RSP: if (rx_valid) begin
          if (rx_frame_err || cmd_q.write) begin
            rsp_error <= rx_frame_err || (rx_byte != UART_ACK);
            rsp_data  <= 16'd0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == 3'd1) begin
            rsp_error <= 1'b0;
            rsp_data  <= {rd_hi, rx_byte};
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rd_hi <= rx_byte;
            idx   <= idx + 3'd1;
          end
        end else if (tmo_hit) begin
          rsp_error <= 1'b1;
          rsp_data  <= 16'd0;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: decodes uart_tx, plays the responder on uart_rx, and checks
// frames and responses against a protocol-level model, plus timeout and mid-frame reset sequences.
module tb_uart_cmd_master;

  localparam int D = 8;
  localparam int TMO = 100;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          nrep;
    logic [7:0]  r0;
    logic [7:0]  r1;
    bit          bad_stop;
    bit          glitch;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, uart_rx, uart_tx, cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_wdata, rsp_data;
  logic        rsp_valid, rsp_error, busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  tx_q[$];

  bit          got_rsp;
  logic        got_err, got_ready, post_vld, post_ready;
  logic [15:0] got_data, post_data;
  int          got_cyc;

  uart_cmd_master #(.DELAY_FRAMES(D), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: find the start bit, then sample each bit in its middle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (D) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_frame(input vec_t v, output logic [7:0] f[5], output int n);
    f[0] = v.wr ? 8'h57 : 8'h52;
    f[1] = v.addr[15:8];
    f[2] = v.addr[7:0];
    f[3] = v.wdata[15:8];
    f[4] = v.wdata[7:0];
    n    = v.wr ? 5 : 3;
  endtask

  task automatic model_rsp(input vec_t v, output logic e, output logic [15:0] d);
    if (v.bad_stop) begin
      e = 1'b1; d = 16'h0;
    end else if (v.wr) begin
      e = (v.r0 != 8'h4B); d = 16'h0;
    end else begin
      e = 1'b0; d = {v.r0, v.r1};
    end
  endtask

  task automatic drive_cmd(input bit wr, input logic [15:0] a, input logic [15:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'h1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 16'($urandom); cmd_wdata = 16'($urandom);
    chk("start_bit_n_plus_1", 32'(uart_tx), 32'h0);
    chk("ready_low_n_plus_1", 32'(cmd_ready), 32'h0);
    chk("busy_high", 32'(busy), 32'h1);
  endtask

  task automatic wait_bytes(input int cnt, input int budget);
    for (int n = 0; n < budget && tx_q.size() < cnt; n++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    uart_rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (D) @(negedge clk);
    end
    uart_rx = stop;
    repeat (D) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_reply(input vec_t v);
    for (int i = 0; i < v.nrep; i++)
      send_byte((i == 0) ? v.r0 : v.r1, !(v.bad_stop && i == v.nrep - 1));
  endtask

  task automatic wait_rsp(input int budget);
    got_rsp = 1'b0;
    for (int n = 0; n < budget && !got_rsp; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got_rsp = 1'b1; got_err = rsp_error; got_data = rsp_data;
        got_ready = cmd_ready; got_cyc = cyc;
      end
    end
    if (got_rsp) begin
      @(negedge clk);
      post_vld = rsp_valid; post_ready = cmd_ready; post_data = rsp_data;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] f[5];
    int n, acc;
    model_frame(v, f, n);
    tx_q.delete();
    drive_cmd(v.wr, v.addr, v.wdata, acc);
    wait_bytes(n, 60 * D + 50);
    chk("frame_len", 32'(tx_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < tx_q.size()) chk($sformatf("frame_byte%0d", i), 32'(tx_q[i]), 32'(f[i]));
    repeat (D) @(negedge clk);
    if (v.glitch) begin
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * D) @(negedge clk);
    end
    fork
      send_reply(v);
      wait_rsp(40 * D);
    join
    chk("rsp_seen", 32'(got_rsp), 32'h1);
    chk("rsp_error", 32'(got_err), 32'(v.exp_err));
    chk("rsp_data", 32'(got_data), 32'(v.exp_data));
    chk("ready_at_pulse", 32'(got_ready), 32'h0);
    chk("pulse_one_cycle", 32'(post_vld), 32'h0);
    chk("ready_after_pulse", 32'(post_ready), 32'h1);
    chk("rsp_data_hold", 32'(post_data), 32'(v.exp_data));
  endtask

  initial begin
    vec_t tbl[9];
    int acc;
    logic e;
    logic [15:0] d;

    tbl[0] = '{wr:1, addr:16'h0012, wdata:16'hBEEF, nrep:1, r0:8'h4B, r1:8'h00, bad_stop:0, glitch:0, exp_err:0, exp_data:16'h0000};
    tbl[1] = '{wr:0, addr:16'h00FF, wdata:16'h0000, nrep:2, r0:8'h12, r1:8'h34, bad_stop:0, glitch:1, exp_err:0, exp_data:16'h1234};
    tbl[2] = '{wr:0, addr:16'hA5C3, wdata:16'h0000, nrep:2, r0:8'hDE, r1:8'hAD, bad_stop:1, glitch:0, exp_err:1, exp_data:16'h0000};
    tbl[3] = '{wr:1, addr:16'h1234, wdata:16'h5678, nrep:1, r0:8'h4E, r1:8'h00, bad_stop:0, glitch:0, exp_err:1, exp_data:16'h0000};
    for (int i = 4; i < 8; i++) begin
      tbl[i].wr       = 1'($urandom_range(0, 1));
      tbl[i].addr     = 16'($urandom);
      tbl[i].wdata    = 16'($urandom);
      tbl[i].nrep     = tbl[i].wr ? 1 : 2;
      tbl[i].r0       = (tbl[i].wr && $urandom_range(0, 1) == 1) ? 8'h4B : 8'($urandom);
      tbl[i].r1       = 8'($urandom);
      tbl[i].bad_stop = ($urandom_range(0, 3) == 0);
      tbl[i].glitch   = 1'b0;
      model_rsp(tbl[i], e, d);
      tbl[i].exp_err  = e;
      tbl[i].exp_data = d;
    end
    tbl[8] = '{wr:0, addr:16'h0102, wdata:16'h0000, nrep:2, r0:8'h55, r1:8'hAA, bad_stop:0, glitch:0, exp_err:0, exp_data:16'h55AA};

    rst_n = 1'b0; uart_rx = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 16'h0; cmd_wdata = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'h1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_error", 32'(rsp_error), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Read with no reply at all.
    tx_q.delete();
    drive_cmd(1'b0, 16'h0040, 16'h0000, acc);
`ifdef UART_CMD_TIMEOUT_EN
    wait_rsp(30 * D + TMO + 50);
    chk("tmo_pulse", 32'(got_rsp), 32'h1);
    chk("tmo_error", 32'(got_err), 32'h1);
    chk("tmo_data", 32'(got_data), 32'h0);
    chk("tmo_cycles", 32'(got_cyc - acc), 32'(30 * D + 1 + TMO));
`else
    wait_rsp(10_000);
    chk("no_tmo_pulse", 32'(got_rsp), 32'h0);
    chk("still_busy", 32'(busy), 32'h1);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of byte 2 of a write frame.
    tx_q.delete();
    drive_cmd(1'b1, 16'h3344, 16'h5566, acc);
    repeat (22 * D) @(negedge clk);
    chk("mid_frame_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_uart_tx", 32'(uart_tx), 32'h1);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    repeat (12 * D) @(negedge clk);
    chk("rstmid_line_idle", 32'(uart_tx), 32'h1);
    run_vec(tbl[8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
